matmul_job_seq: RTL and testbench

//  Upstream job sequencer for the matmul engine. Accepts matrix-multiply job

---
 rtl/matmul_pkg.sv | 35 +++
 rtl/matmul_job_seq_if.sv | 45 ++++
 rtl/matmul_job_fifo.sv | 48 ++++
 rtl/matmul_job_seq.sv | 149 ++++++++++++++
 tb/tb_matmul_job_seq.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul job sequencer.
//   MEM_AW      address width of the matrix base addresses
//   DIM_BITS    width of strides and dimensions
//   TAG_W       job tag width
//   DONE_CYC_W  width of the engine run-time counter
//   job_desc_t  one queued job: tag, bases, strides, dimensions
//   seq_state_t sequencer FSM states
package matmul_pkg;

    localparam int unsigned MEM_AW     = 16;
    localparam int unsigned DIM_BITS   = 16;
    localparam int unsigned TAG_W      = 8;
    localparam int unsigned DONE_CYC_W = 32;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [MEM_AW-1:0]   abase;
        logic [MEM_AW-1:0]   bbase;
        logic [MEM_AW-1:0]   cbase;
        logic [DIM_BITS-1:0] astride;
        logic [DIM_BITS-1:0] bstride;
        logic [DIM_BITS-1:0] cstride;
        logic [DIM_BITS-1:0] arows;
        logic [DIM_BITS-1:0] acols;
        logic [DIM_BITS-1:0] bcols;
    } job_desc_t;

    typedef enum logic [2:0] {StGap, StIdle, StGo, StBusy, StResp} seq_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DONE_CYC_W-1:0] sat_inc(input logic [DONE_CYC_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/matmul_job_seq_if.sv
// Bundle of all non-clock/reset signals of matmul_job_seq.
//   job_*        descriptor input port (valid/ready)
//   aBASE..bCOLS engine descriptor outputs; go/ret engine handshake
//   done_*       completion record port (valid/ready)
//   spurious_ret sticky error flag
// Modports: slave = sequencer side, master = host + engine side.
interface matmul_job_seq_if;
    import matmul_pkg::*;

    logic                  job_vld;
    logic                  job_rdy;
    logic [TAG_W-1:0]      job_tag;
    logic [MEM_AW-1:0]     job_abase, job_bbase, job_cbase;
    logic [DIM_BITS-1:0]   job_astride, job_bstride, job_cstride;
    logic [DIM_BITS-1:0]   job_arows, job_acols, job_bcols;

    logic [MEM_AW-1:0]     aBASE, bBASE, cBASE;
    logic [DIM_BITS-1:0]   aSTRIDE, bSTRIDE, cSTRIDE;
    logic [DIM_BITS-1:0]   aROWS, aCOLS, bCOLS;
    logic                  go;
    logic                  ret;

    logic                  done_vld;
    logic                  done_rdy;
    logic [TAG_W-1:0]      done_tag;
    logic [DONE_CYC_W-1:0] done_cycles;
    logic                  spurious_ret;

    modport slave (
        input  job_vld, job_tag, job_abase, job_bbase, job_cbase,
               job_astride, job_bstride, job_cstride, job_arows, job_acols, job_bcols,
               ret, done_rdy,
        output job_rdy, aBASE, bBASE, cBASE, aSTRIDE, bSTRIDE, cSTRIDE,
               aROWS, aCOLS, bCOLS, go, done_vld, done_tag, done_cycles, spurious_ret
    );

    modport master (
        output job_vld, job_tag, job_abase, job_bbase, job_cbase,
               job_astride, job_bstride, job_cstride, job_arows, job_acols, job_bcols,
               ret, done_rdy,
        input  job_rdy, aBASE, bBASE, cBASE, aSTRIDE, bSTRIDE, cSTRIDE,
               aROWS, aCOLS, bCOLS, go, done_vld, done_tag, done_cycles, spurious_ret
    );

endinterface

// File: rtl/matmul_job_fifo.sv
// Synchronous DEPTH-entry FIFO of job descriptors.
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   write request (ignored when full)
//   pop, rdata    read request (ignored when empty); rdata is the current head
//   full, empty   status from registered pointers only
module matmul_job_fifo
    import matmul_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  job_desc_t wdata,
    input  logic      pop,
    output job_desc_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_q, rd_q;
    job_desc_t   mem_q [DEPTH];
    logic        push_ok, pop_ok;

    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty   = (wr_q == rd_q);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/matmul_job_seq.sv
// Job sequencer in front of the matmul engine: queues descriptors, dispatches
// one job at a time with a go pulse, waits for ret, returns a tagged completion.
//   clk, rst  clock, synchronous active-high reset (drops queued/in-flight jobs)
//   bus       matmul_job_seq_if.slave: job port, engine port, done port, spurious_ret
// Parameters: DEPTH (FIFO entries, power of 2, >=2), GO_GAP (idle cycles between
// ret/reset release and the next go). Widths come from matmul_pkg.
// Optional feature: define MATMUL_JOB_SEQ_CYCLES_EN to report the engine run time
// in done_cycles; otherwise done_cycles is tied to 0.
module matmul_job_seq
    import matmul_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned GO_GAP = 2
) (
    input logic             clk,
    input logic             rst,
    matmul_job_seq_if.slave bus
);

    localparam int unsigned       GapW    = (GO_GAP > 1) ? $clog2(GO_GAP) : 1;
    localparam logic [GapW-1:0]   GapLast = GapW'((GO_GAP > 0) ? GO_GAP - 1 : 0);

    seq_state_t       state_q, state_d;
    logic [GapW-1:0]  gap_q, gap_d;
    job_desc_t        desc_q, desc_d, in_desc, head_desc;
    logic [TAG_W-1:0] done_tag_q, done_tag_d;
    logic             spur_q, spur_d;
    logic             full, empty, pop, gap_done;

    assign in_desc = '{tag: bus.job_tag, abase: bus.job_abase, bbase: bus.job_bbase,
                       cbase: bus.job_cbase, astride: bus.job_astride,
                       bstride: bus.job_bstride, cstride: bus.job_cstride,
                       arows: bus.job_arows, acols: bus.job_acols, bcols: bus.job_bcols};

    matmul_job_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.job_vld),
        .wdata (in_desc),
        .pop   (pop),
        .rdata (head_desc),
        .full  (full),
        .empty (empty)
    );

    assign gap_done = (GO_GAP == 0) || (gap_q == GapLast);

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        desc_d     = desc_q;
        done_tag_d = done_tag_q;
        pop        = 1'b0;
        spur_d     = spur_q || (bus.ret && (state_q != StBusy));
        unique case (state_q)
            StGap: begin
                if (gap_done) begin
                    state_d = StIdle;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    desc_d  = head_desc;
                    state_d = StGo;
                end
            end
            StGo: state_d = StBusy;
            StBusy: begin
                if (bus.ret) begin
                    done_tag_d = desc_q.tag;
                    state_d    = StResp;
                end
            end
            StResp: begin
                if (bus.done_rdy) begin
                    gap_d   = '0;
                    state_d = StGap;
                end
            end
            default: state_d = StGap;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StGap;
            gap_q      <= '0;
            desc_q     <= '0;
            done_tag_q <= '0;
            spur_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            desc_q     <= desc_d;
            done_tag_q <= done_tag_d;
            spur_q     <= spur_d;
        end
    end

`ifdef MATMUL_JOB_SEQ_CYCLES_EN
    // Counts the GO cycle plus every BUSY cycle up to and including the ret cycle.
    logic [DONE_CYC_W-1:0] cyc_q, cyc_d, done_cyc_q, done_cyc_d;

    always_comb begin
        cyc_d      = cyc_q;
        done_cyc_d = done_cyc_q;
        if (state_q == StGo) begin
            cyc_d = DONE_CYC_W'(1);
        end else if (state_q == StBusy) begin
            cyc_d = sat_inc(cyc_q);
            if (bus.ret) done_cyc_d = sat_inc(cyc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q      <= '0;
            done_cyc_q <= '0;
        end else begin
            cyc_q      <= cyc_d;
            done_cyc_q <= done_cyc_d;
        end
    end

    assign bus.done_cycles = done_cyc_q;
`else
    assign bus.done_cycles = '0;
`endif

    assign bus.job_rdy      = !full;
    assign bus.go           = (state_q == StGo);
    assign bus.done_vld     = (state_q == StResp);
    assign bus.done_tag     = done_tag_q;
    assign bus.spurious_ret = spur_q;
    assign bus.aBASE        = desc_q.abase;
    assign bus.bBASE        = desc_q.bbase;
    assign bus.cBASE        = desc_q.cbase;
    assign bus.aSTRIDE      = desc_q.astride;
    assign bus.bSTRIDE      = desc_q.bstride;
    assign bus.cSTRIDE      = desc_q.cstride;
    assign bus.aROWS        = desc_q.arows;
    assign bus.aCOLS        = desc_q.acols;
    assign bus.bCOLS        = desc_q.bcols;

endmodule

// File: tb/tb_matmul_job_seq.sv
// Directed testbench for matmul_job_seq (DEPTH=4, GO_GAP=2) with a simple
// engine model that returns ret eng_lat cycles after go and aborts on rst.
// Honours MATMUL_JOB_SEQ_CYCLES_EN for the expected done_cycles value.
module tb_matmul_job_seq;

`ifdef MATMUL_JOB_SEQ_CYCLES_EN
    localparam bit CycEn = 1'b1;
`else
    localparam bit CycEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matmul_job_seq_if bus ();

    matmul_job_seq #(.DEPTH(4), .GO_GAP(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int eng_lat = 20;
    int go_overlap = 0;
    bit zero_dims = 1'b0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cyc(input int lat);
        return CycEn ? 32'(lat + 1) : 32'd0;
    endfunction

    // Engine model: ret is sampled at the edge ending the lat-th cycle after go.
    initial begin : engine
        bit abort;
        forever begin
            @(negedge clk);
            if (bus.go && !rst) begin
                abort = 1'b0;
                for (int i = 0; i < eng_lat; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        abort = 1'b1;
                        break;
                    end
                    if (bus.go) go_overlap++;
                end
                if (!abort) begin
                    bus.ret = 1'b1;
                    @(negedge clk);
                    bus.ret = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_job(input logic [7:0] tag, output bit ok);
        bus.job_tag     = tag;
        bus.job_abase   = {tag, 8'h10};
        bus.job_bbase   = {tag, 8'h20};
        bus.job_cbase   = {tag, 8'h30};
        bus.job_astride = 16'h0100 + 16'(tag);
        bus.job_bstride = 16'h0200 + 16'(tag);
        bus.job_cstride = 16'h0300 + 16'(tag);
        bus.job_arows   = zero_dims ? 16'h0 : 16'h1000 + 16'(tag);
        bus.job_acols   = zero_dims ? 16'h0 : 16'h2000 + 16'(tag);
        bus.job_bcols   = zero_dims ? 16'h0 : 16'h3000 + 16'(tag);
        bus.job_vld     = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.job_rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.job_vld = 1'b0;
    endtask

    task automatic wait_go(output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (bus.go) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Returns at the negedge after the first cycle with done_vld seen.
    task automatic wait_done(output int n, output logic [7:0] tag, output logic [31:0] cyc,
                             output bit ok);
        n = 0;
        ok = 1'b0;
        tag = '0;
        cyc = '0;
        for (int i = 0; i < 400; i++) begin
            if (bus.done_vld) begin
                ok = 1'b1;
                tag = bus.done_tag;
                cyc = bus.done_cycles;
                break;
            end
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : main
        bit ok;
        bit flag;
        int n;
        logic [7:0] tag;
        logic [31:0] cyc;

        bus.job_vld = 1'b0;
        bus.job_tag = '0;
        bus.job_abase = '0;
        bus.job_bbase = '0;
        bus.job_cbase = '0;
        bus.job_astride = '0;
        bus.job_bstride = '0;
        bus.job_cstride = '0;
        bus.job_arows = '0;
        bus.job_acols = '0;
        bus.job_bcols = '0;
        bus.ret = 1'b0;
        bus.done_rdy = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_go", 64'(bus.go), 64'd0);
        chk("rst_done_vld", 64'(bus.done_vld), 64'd0);
        chk("rst_job_rdy", 64'(bus.job_rdy), 64'd1);
        chk("rst_spurious", 64'(bus.spurious_ret), 64'd0);
        chk("rst_abase", 64'(bus.aBASE), 64'd0);
        chk("rst_done_cycles", 64'(bus.done_cycles), 64'd0);
        rst = 1'b0;

        // 1: single job, go GO_GAP+1 cycles after reset release
        eng_lat = 20;
        push_job(8'h5A, ok);
        chk("t1_push", 64'(ok), 64'd1);
        wait_go(n, ok);
        chk("t1_go_seen", 64'(ok), 64'd1);
        chk("t1_go_delay", 64'(n + 1), 64'd3);
        chk("t1_abase", 64'(bus.aBASE), 64'h5A10);
        chk("t1_bbase", 64'(bus.bBASE), 64'h5A20);
        chk("t1_cbase", 64'(bus.cBASE), 64'h5A30);
        chk("t1_astride", 64'(bus.aSTRIDE), 64'h015A);
        chk("t1_cstride", 64'(bus.cSTRIDE), 64'h035A);
        chk("t1_arows", 64'(bus.aROWS), 64'h105A);
        chk("t1_bcols", 64'(bus.bCOLS), 64'h305A);
        wait_done(n, tag, cyc, ok);
        chk("t1_done_seen", 64'(ok), 64'd1);
        chk("t1_done_delay", 64'(n), 64'd21);
        chk("t1_done_tag", 64'(tag), 64'h5A);
        chk("t1_done_cycles", 64'(cyc), 64'(exp_cyc(20)));
        chk("t1_done_cleared", 64'(bus.done_vld), 64'd0);

        // 3: consumer stalls, record stays stable, next go waits for handshake+gap
        bus.done_rdy = 1'b0;
        eng_lat = 5;
        push_job(8'h33, ok);
        wait_done(n, tag, cyc, ok);
        chk("t3_done_seen", 64'(ok), 64'd1);
        chk("t3_done_tag", 64'(tag), 64'h33);
        chk("t3_done_cycles", 64'(cyc), 64'(exp_cyc(5)));
        push_job(8'h44, ok);
        flag = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!(bus.done_vld && bus.done_tag == 8'h33 && bus.done_cycles == exp_cyc(5)
                  && !bus.go)) flag = 1'b0;
        end
        chk("t3_hold_stable", 64'(flag), 64'd1);
        bus.done_rdy = 1'b1;
        wait_go(n, ok);
        chk("t3_go_after_hs", 64'(n), 64'd4);
        wait_done(n, tag, cyc, ok);
        chk("t3_done2_delay", 64'(n), 64'd6);
        chk("t3_done2_tag", 64'(tag), 64'h44);

        // 2: FIFO fills behind a busy engine; completions in order
        do_reset();
        eng_lat = 20;
        push_job(8'd1, ok);
        wait_go(n, ok);
        chk("t2_go1", 64'(ok), 64'd1);
        flag = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            push_job(8'(k), ok);
            if (!ok) flag = 1'b0;
        end
        chk("t2_pushes_ok", 64'(flag), 64'd1);
        chk("t2_full_rdy", 64'(bus.job_rdy), 64'd0);
        wait_done(n, tag, cyc, ok);
        chk("t2_tag1", 64'(tag), 64'd1);
        chk("t2_still_full", 64'(bus.job_rdy), 64'd0);
        for (int k = 2; k <= 5; k++) begin
            wait_done(n, tag, cyc, ok);
            chk($sformatf("t2_tag%0d", k), 64'(tag), 64'(k));
        end
        chk("t2_drained_rdy", 64'(bus.job_rdy), 64'd1);

        // 4: ret while IDLE is flagged and ignored
        do_reset();
        repeat (5) @(negedge clk);
        bus.ret = 1'b1;
        @(negedge clk);
        bus.ret = 1'b0;
        chk("t4_spurious_set", 64'(bus.spurious_ret), 64'd1);
        flag = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done_vld || bus.go) flag = 1'b1;
        end
        chk("t4_no_done", 64'(flag), 64'd0);
        zero_dims = 1'b1;
        eng_lat = 3;
        push_job(8'h77, ok);
        wait_done(n, tag, cyc, ok);
        zero_dims = 1'b0;
        chk("t4_done_tag", 64'(tag), 64'h77);
        chk("t4_done_cycles", 64'(cyc), 64'(exp_cyc(3)));
        chk("t4_zero_rows", 64'(bus.aROWS), 64'd0);
        chk("t4_zero_bcols", 64'(bus.bCOLS), 64'd0);
        chk("t4_spurious_sticky", 64'(bus.spurious_ret), 64'd1);

        // 5: reset while BUSY with two jobs queued
        eng_lat = 20;
        push_job(8'h81, ok);
        wait_go(n, ok);
        push_job(8'h82, ok);
        push_job(8'h83, ok);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_go", 64'(bus.go), 64'd0);
        chk("t5_done_vld", 64'(bus.done_vld), 64'd0);
        chk("t5_done_tag", 64'(bus.done_tag), 64'd0);
        chk("t5_done_cycles", 64'(bus.done_cycles), 64'd0);
        chk("t5_spurious", 64'(bus.spurious_ret), 64'd0);
        chk("t5_abase", 64'(bus.aBASE), 64'd0);
        chk("t5_arows", 64'(bus.aROWS), 64'd0);
        chk("t5_job_rdy", 64'(bus.job_rdy), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        flag = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (bus.done_vld || bus.go) flag = 1'b1;
        end
        chk("t5_dropped", 64'(flag), 64'd0);

        chk("go_overlap", 64'(go_overlap), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
